// File: rtl/fifo_pkg.sv
// Shared definitions for the word/byte packing and unpacking FIFOs.
package fifo_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef logic [LANE_W-1:0] lane_t;

    // Select byte lane 'sel' of a word; lane 0 is the least significant byte.
    function automatic logic [BYTE_W-1:0] lane_sel(input logic [WORD_W-1:0] w,
                                                   input lane_t             sel);
        return w[int'(sel)*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/fifo_word_mem.sv
// DEPTH x 32 word store: synchronous write port, asynchronous read port.
module fifo_word_mem
    import fifo_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage has no reset; the pointers guarantee stale words are never read.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_word2byte.sv
// Unpacking FIFO: 32-bit words in, bytes out lowest lane first, one-cycle
// registered read latency.
module fifo_word2byte
    import fifo_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_in,
    input  logic              wr_en,
    output logic              full,
    input  logic              rd_en,
    output logic              empty,
    output logic [BYTE_W-1:0] data_out,
    output logic              out_valid,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam lane_t           LAST_LANE  = LANE_W'(BYTES_PER_WORD-1);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   word_count;
    lane_t             byte_sel;
    logic [WORD_W-1:0] head_word;

    logic wr_acc, rd_acc, word_free;

    // Flags come from pre-edge state, so a same-cycle freeing read cannot
    // make room for a write, nor a same-cycle write feed a read.
    assign full      = (word_count == COUNT_FULL);
    assign empty     = (word_count == '0);
    assign wr_acc    = wr_en && !full;
    assign rd_acc    = rd_en && !empty;
    assign word_free = rd_acc && (byte_sel == LAST_LANE);

    fifo_word_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && !rst),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (head_word)
    );

    // Pointers, occupancy and lane select.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_count <= '0;
            byte_sel   <= '0;
        end else begin
            if (wr_acc)    wr_ptr   <= wr_ptr + 1'b1;
            if (word_free) rd_ptr   <= rd_ptr + 1'b1;
            if (rd_acc)    byte_sel <= byte_sel + 1'b1;  // wraps 3 -> 0
            if (wr_acc && !word_free)      word_count <= word_count + 1'b1;
            else if (word_free && !wr_acc) word_count <= word_count - 1'b1;
        end
    end

    // Registered byte output, valid pulse and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= rd_acc;
            if (rd_acc)          data_out  <= lane_sel(head_word, byte_sel);
            if (wr_en && full)   overflow  <= 1'b1;
            if (rd_en && empty)  underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_word2byte.sv
// Directed self-checking bench for fifo_word2byte.
module tb_fifo_word2byte;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        wr_en;
    logic        full;
    logic        rd_en;
    logic        empty;
    logic [7:0]  data_out;
    logic        out_valid;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    fifo_word2byte #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .wr_en     (wr_en),
        .full      (full),
        .rd_en     (rd_en),
        .empty     (empty),
        .data_out  (data_out),
        .out_valid (out_valid),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // One clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] w);
        wr_en = 1'b1; data_in = w;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 32'hFFFF_FFFF;
        step(); step();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++; $display("FAIL reset_sticky got=%b%b exp=00", overflow, underflow); end
    endtask

    task automatic test_single_word();
        logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        put_word(32'h44332211);
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL single_nonempty got=%b exp=0", empty); end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (data_out !== exp[i] || out_valid !== 1'b1) begin
                failures++; $display("FAIL single_byte%0d got=%h/%b exp=%h/1", i, data_out, out_valid, exp[i]); end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%b exp=1", empty); end
        step();
        checks++; if (out_valid !== 1'b0 || data_out !== 8'h44) begin
            failures++; $display("FAIL single_hold got=%h/%b exp=44/0", data_out, out_valid); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL single_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_full_overflow();
        logic [31:0] words [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        for (int i = 0; i < 4; i++) begin
            checks++; if (full !== 1'b0) begin failures++; $display("FAIL fill_notfull%0d got=%b exp=0", i, full); end
            put_word(words[i]);
        end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_no_ovf got=%b exp=0", overflow); end
        put_word(32'hDEADBEEF);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", overflow); end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++; if (data_out !== 8'(i) || out_valid !== 1'b1) begin
                failures++; $display("FAIL full_byte%0d got=%h/%b exp=%h/1", i, data_out, out_valid, 8'(i)); end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drained got=%b exp=1", empty); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_full_simul();
        logic [31:0] words [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
        do_reset();
        for (int i = 0; i < 4; i++) put_word(words[i]);
        rd_en = 1'b1;
        step(); step(); step();
        // 4th byte of the head word together with a write while full.
        wr_en = 1'b1; data_in = 32'hCAFEF00D;
        step();
        wr_en = 1'b0;
        checks++; if (data_out !== 8'h13) begin failures++; $display("FAIL simul_full_byte got=%h exp=13", data_out); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL simul_full_deassert got=%b exp=0", full); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL simul_full_ovf got=%b exp=1", overflow); end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++; if (data_out !== 8'(8'h14 + i)) begin
                failures++; $display("FAIL simul_full_rest%0d got=%h exp=%h", i, data_out, 8'(8'h14 + i)); end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL simul_full_dropped got=%b exp=1", empty); end
    endtask

    task automatic test_empty_simul();
        do_reset();
        wr_en = 1'b1; rd_en = 1'b1; data_in = 32'hA5A5A5A5;
        step();
        wr_en = 1'b0;
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL simul_empty_udf got=%b exp=1", underflow); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL simul_empty_valid got=%b exp=0", out_valid); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL simul_empty_stored got=%b exp=0", empty); end
        step();
        checks++; if (data_out !== 8'hA5 || out_valid !== 1'b1) begin
            failures++; $display("FAIL simul_empty_byte got=%h/%b exp=a5/1", data_out, out_valid); end
        step(); step(); step();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL simul_empty_drained got=%b exp=1", empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c <= 48; c++) begin
            wr_en   = (c % 4 == 0) && (c / 4 < 12);
            data_in = {8'(4*(c/4)+3), 8'(4*(c/4)+2), 8'(4*(c/4)+1), 8'(4*(c/4))};
            rd_en   = (c >= 1);
            step();
            if (c >= 1) begin
                checks++; if (data_out !== 8'(c-1) || out_valid !== 1'b1) begin
                    failures++; $display("FAIL stream_byte%0d got=%h/%b exp=%h/1", c-1, data_out, out_valid, 8'(c-1)); end
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL stream_empty got=%b exp=1", empty); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++; $display("FAIL stream_flags got=%b%b exp=00", overflow, underflow); end
    endtask

    task automatic test_reset_mid();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL mid_udf_set got=%b exp=1", underflow); end
        put_word(32'hDDCCBBAA);
        rd_en = 1'b1;
        step();
        checks++; if (data_out !== 8'hAA) begin failures++; $display("FAIL mid_b0 got=%h exp=aa", data_out); end
        step();
        checks++; if (data_out !== 8'hBB) begin failures++; $display("FAIL mid_b1 got=%h exp=bb", data_out); end
        rst = 1'b1;
        step();
        rst = 1'b0; rd_en = 1'b0;
        checks++; if (empty !== 1'b1 || data_out !== 8'h00 || out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_reset got=%b/%h/%b exp=1/00/0", empty, data_out, out_valid); end
        checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin
            failures++; $display("FAIL mid_flags got=%b%b exp=00", overflow, underflow); end
        put_word(32'h89674523);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (data_out !== 8'h23 || out_valid !== 1'b1) begin
            failures++; $display("FAIL mid_newword got=%h/%b exp=23/1", data_out, out_valid); end
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        test_reset();
        test_single_word();
        test_full_overflow();
        test_full_simul();
        test_empty_simul();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
